// File: rtl/ternary_word_decoder_if.sv
// Trit-stream input and decoded-word output handshake bundle for ternary_word_decoder.
// master = trit producer / word consumer side, slave = decoder side.
interface ternary_word_decoder_if #(
    parameter int unsigned W = 16
);
    logic [1:0]          in_trit;
    logic                in_sof;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] out_data;
    logic                out_err;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_trit, in_sof, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_trit, in_sof, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/ternary_word_decoder.sv
// Balanced-ternary serial decoder: MSB-first 2-bit trits accumulate into a signed W-bit word.
// Define TERNARY_DECODER_ERR_CHECK_EN to build the sticky illegal-code (2'b11) flag on out_err.
module ternary_word_decoder #(
    parameter int unsigned N_TRITS = 9,
    parameter int unsigned W       = 16
) (
    input logic                   clk,
    input logic                   rst,
    ternary_word_decoder_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(N_TRITS + 1);

    localparam logic [1:0] TRIT_NEG  = 2'b00;
    localparam logic [1:0] TRIT_ZERO = 2'b01;
    localparam logic [1:0] TRIT_POS  = 2'b10;
    localparam logic [1:0] TRIT_BAD  = 2'b11;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t              state;
    logic signed [W-1:0] acc;
    logic signed [W-1:0] acc_base;
    logic signed [W-1:0] acc_next;
    logic signed [W-1:0] trit_val;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic                accept;
    logic                word_done;

    assign accept = bus.in_valid && bus.in_ready;

    // Trit decode and next accumulator: 3*acc + t, restarting from zero on start-of-word.
    always_comb begin
        trit_val = '0;
        unique case (bus.in_trit)
            TRIT_NEG:            trit_val = '1;
            TRIT_POS:            trit_val = W'(1);
            TRIT_ZERO, TRIT_BAD: trit_val = '0;
        endcase
        acc_base   = bus.in_sof ? '0 : acc;
        acc_next   = acc_base + (acc_base << 1) + trit_val;
        count_next = bus.in_sof ? CNT_W'(1) : count + CNT_W'(1);
        word_done  = accept && (count_next == CNT_W'(N_TRITS));
    end

`ifdef TERNARY_DECODER_ERR_CHECK_EN
    logic err;
    logic err_next;

    // Sticky flag restarts with each word; an illegal trit still contributes 0 to the value.
    always_comb begin
        err_next = (((bus.in_sof || (count == '0)) ? 1'b0 : err) || (bus.in_trit == TRIT_BAD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err         <= 1'b0;
            bus.out_err <= 1'b0;
        end else if (accept) begin
            err <= word_done ? 1'b0 : err_next;
            if (word_done) begin
                bus.out_err <= err_next;
            end
        end
    end
`else
    assign bus.out_err = 1'b0;
`endif

    // COLLECT gathers trits; HOLD presents the word until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            acc           <= '0;
            count         <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        if (word_done) begin
                            bus.out_data  <= acc_next;
                            acc           <= '0;
                            count         <= '0;
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                            bus.in_ready  <= 1'b0;
                        end else begin
                            acc   <= acc_next;
                            count <= count_next;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_valid && bus.out_ready) begin
                        state         <= COLLECT;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= COLLECT;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
